// File: rtl/ft64_regfile_wrq_if.sv
// Commit-side, register-file-side and lookup signals of the
// write-back queue in front of the 3-write-port register file.
interface ft64_regfile_wrq_if #(
  parameter int WID   = 64,
  parameter int RBIT  = 11,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]      cv;
  logic [RBIT:0]   ca0, ca1, ca2, ca3;
  logic [WID-1:0]  cd0, cd1, cd2, cd3;
  logic            crdy;
  logic            wr0, wr1, wr2;
  logic [RBIT:0]   wa0, wa1, wa2;
  logic [WID-1:0]  wd0, wd1, wd2;
  logic [RBIT:0]   qa;
  logic            qhit;
  logic [WID-1:0]  qdata;
  logic [CW-1:0]   count;

  modport master (
    output cv, ca0, ca1, ca2, ca3,
    output cd0, cd1, cd2, cd3, qa,
    input  crdy, wr0, wr1, wr2,
    input  wa0, wa1, wa2,
    input  wd0, wd1, wd2,
    input  qhit, qdata, count
  );

  modport slave (
    input  cv, ca0, ca1, ca2, ca3,
    input  cd0, cd1, cd2, cd3, qa,
    output crdy, wr0, wr1, wr2,
    output wa0, wa1, wa2,
    output wd0, wd1, wd2,
    output qhit, qdata, count
  );
endinterface

// File: rtl/ft64_regfile_wrq.sv
// Write-back queue: takes up to 4 commits per cycle, drains up to
// 3 per cycle onto the register file, with an operand lookup port.
module ft64_regfile_wrq #(
  parameter int WID   = 64,
  parameter int RBIT  = 11,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  ft64_regfile_wrq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef logic [AW-1:0] ptr_t;

  logic [RBIT:0]  ra_q [DEPTH];
  logic [WID-1:0] rd_q [DEPTH];
  ptr_t           head_q, head_d;
  ptr_t           tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2:0]     wr_q, wr_d;
  logic [RBIT:0]  wa_q [3];
  logic [RBIT:0]  wa_d [3];
  logic [WID-1:0] wd_q [3];
  logic [WID-1:0] wd_d [3];

  logic [RBIT:0]  la [4];
  logic [WID-1:0] ld [4];
  logic [3:0]     wen;
  ptr_t           widx [4];
  logic [2:0]     nin;
  logic [1:0]     nout;
  logic           crdy;
  logic           qhit;
  logic [WID-1:0] qdata;

  always_comb begin
    la[0] = bus.ca0;
    la[1] = bus.ca1;
    la[2] = bus.ca2;
    la[3] = bus.ca3;
    ld[0] = bus.cd0;
    ld[1] = bus.cd1;
    ld[2] = bus.cd2;
    ld[3] = bus.cd3;
    crdy = !rst && (count_q <= CW'(DEPTH - 4));
    nin  = '0;
    // Compact valid lanes onto consecutive slots in lane order
    for (int l = 0; l < 4; l++) begin
      wen[l]  = crdy && bus.cv[l] && (la[l] != '0);
      widx[l] = tail_q + ptr_t'(nin);
      nin     = nin + {2'b00, wen[l]};
    end
  end

  always_comb begin
    nout    = (count_q >= CW'(3)) ? 2'd3 : count_q[1:0];
    head_d  = head_q + ptr_t'(nout);
    tail_d  = tail_q + ptr_t'(nin);
    count_d = count_q + CW'(nin) - CW'(nout);
    wr_d    = '0;
    for (int k = 0; k < 3; k++) begin
      wa_d[k] = wa_q[k];
      wd_d[k] = wd_q[k];
      if (k < int'(nout)) begin
        wr_d[k] = 1'b1;
        wa_d[k] = ra_q[head_q + ptr_t'(k)];
        wd_d[k] = rd_q[head_q + ptr_t'(k)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wr_q    <= '0;
      for (int k = 0; k < 3; k++) begin
        wa_q[k] <= '0;
        wd_q[k] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      for (int k = 0; k < 3; k++) begin
        wa_q[k] <= wa_d[k];
        wd_q[k] <= wd_d[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (wen[l]) begin
        ra_q[widx[l]] <= la[l];
        rd_q[widx[l]] <= ld[l];
      end
    end
  end

  // Later matches override earlier ones, so the youngest wins
  always_comb begin
    qhit  = 1'b0;
    qdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && bus.qa != '0 &&
          ra_q[head_q + ptr_t'(i)] == bus.qa) begin
        qhit  = 1'b1;
        qdata = rd_q[head_q + ptr_t'(i)];
      end
    end
  end

  assign bus.crdy  = crdy;
  assign bus.wr0   = wr_q[0];
  assign bus.wr1   = wr_q[1];
  assign bus.wr2   = wr_q[2];
  assign bus.wa0   = wa_q[0];
  assign bus.wa1   = wa_q[1];
  assign bus.wa2   = wa_q[2];
  assign bus.wd0   = wd_q[0];
  assign bus.wd1   = wd_q[1];
  assign bus.wd2   = wd_q[2];
  assign bus.qhit  = qhit;
  assign bus.qdata = qdata;
  assign bus.count = count_q;
endmodule
